pfd_tdc: RTL

PFD_TDC -- requirements
Module: pfd_tdc

---
 rtl/pfd_tdc_pkg.sv | 15 +
 rtl/pfd_sync_edge.sv | 39 +++
 rtl/pfd_tdc.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/pfd_tdc_pkg.sv
// pfd_tdc_pkg: shared types and constants for the phase/frequency detector TDC.
//   state_t : measurement FSM states (IDLE, COUNT, SAT)
//   MAG_MAX : saturated magnitude for the default 8-bit magnitude width
package pfd_tdc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    SAT   = 2'd2
  } state_t;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned MAG_MAX   = (1 << DEF_WIDTH) - 1;

endpackage

// File: rtl/pfd_sync_edge.sv
// pfd_sync_edge: multi-flop synchronizer followed by a registered rising-edge
// detector for one asynchronous clock-like input.
//   clk   : sampling clock
//   rstn  : synchronous active-low reset
//   sig   : asynchronous input
//   rise  : one-cycle pulse per rising edge of sig (registered)
// SYNC_STAGES must be at least 2.
module pfd_sync_edge
  import pfd_tdc_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic sig,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;
  // fill marks when prev holds a genuine post-reset sample, so an input that
  // was already high through reset is not reported as an edge.
  logic [SYNC_STAGES:0]   fill;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync <= '0;
      prev <= 1'b0;
      fill <= '0;
      rise <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], sig};
      prev <= sync[SYNC_STAGES-1];
      fill <= {fill[SYNC_STAGES-1:0], 1'b1};
      rise <= sync[SYNC_STAGES-1] & ~prev & fill[SYNC_STAGES];
    end
  end

endmodule

// File: rtl/pfd_tdc.sv
// pfd_tdc: phase/frequency detector with time-to-digital converter.
// Measures the clk-period distance between rising edges of ref_in and fb_in.
//   clk        : sampling clock (much faster than reference)
//   rstn       : synchronous active-low reset
//   ref_in     : asynchronous reference clock
//   fb_in      : asynchronous divided DCO feedback clock
//   master_out : unsigned phase-error magnitude, saturates at 2^WIDTH-1
//   lead       : 1 = feedback edge first, 0 = reference edge first
//   valid      : one-cycle pulse when master_out/lead update
//   lock       : lock indicator (only when PFD_LOCK_DET_EN is defined)
// Optional feature macro: PFD_LOCK_DET_EN
module pfd_tdc
  import pfd_tdc_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned LOCK_THRESH = 4,
  parameter int unsigned LOCK_COUNT  = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             ref_in,
  input  logic             fb_in,
  output logic [WIDTH-1:0] master_out,
  output logic             lead,
  output logic             valid
`ifdef PFD_LOCK_DET_EN
 ,output logic             lock
`endif
);

  localparam logic [WIDTH-1:0] MAG_TOP = '1;
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  logic ref_rise;
  logic fb_rise;

  pfd_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_ref_edge (
    .clk  (clk),
    .rstn (rstn),
    .sig  (ref_in),
    .rise (ref_rise)
  );

  pfd_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_fb_edge (
    .clk  (clk),
    .rstn (rstn),
    .sig  (fb_in),
    .rise (fb_rise)
  );

  state_t           state, state_nxt;
  logic [WIDTH-1:0] cnt, cnt_nxt;
  logic             first_is_fb, first_is_fb_nxt;
  logic [WIDTH-1:0] mag_nxt;
  logic             lead_nxt;
  logic             valid_nxt;

  // Leading/lagging edges are relative to whichever input started the measurement.
  logic lead_rise;
  logic lag_rise;
  assign lead_rise = first_is_fb ? fb_rise  : ref_rise;
  assign lag_rise  = first_is_fb ? ref_rise : fb_rise;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= IDLE;
      cnt         <= '0;
      first_is_fb <= 1'b0;
      master_out  <= '0;
      lead        <= 1'b0;
      valid       <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      first_is_fb <= first_is_fb_nxt;
      master_out  <= mag_nxt;
      lead        <= lead_nxt;
      valid       <= valid_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    first_is_fb_nxt = first_is_fb;
    mag_nxt         = master_out;
    lead_nxt        = lead;
    valid_nxt       = 1'b0;
    unique case (state)
      IDLE: begin
        if (ref_rise && fb_rise) begin
          mag_nxt   = '0;
          lead_nxt  = 1'b1;
          valid_nxt = 1'b1;
        end else if (ref_rise || fb_rise) begin
          first_is_fb_nxt = fb_rise;
          cnt_nxt         = CNT_ONE;
          state_nxt       = COUNT;
        end
      end
      COUNT: begin
        if (lag_rise) begin
          mag_nxt   = cnt;
          lead_nxt  = first_is_fb;
          valid_nxt = 1'b1;
          state_nxt = IDLE;
        end else if (lead_rise) begin
          // Cycle slip: report full scale and start a fresh measurement.
          mag_nxt   = MAG_TOP;
          lead_nxt  = first_is_fb;
          valid_nxt = 1'b1;
          cnt_nxt   = CNT_ONE;
        end else if (cnt == MAG_TOP - CNT_ONE) begin
          cnt_nxt   = MAG_TOP;
          mag_nxt   = MAG_TOP;
          lead_nxt  = first_is_fb;
          valid_nxt = 1'b1;
          state_nxt = SAT;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      SAT: begin
        if (lag_rise) begin
          state_nxt = IDLE;
        end else if (lead_rise) begin
          cnt_nxt   = CNT_ONE;
          state_nxt = COUNT;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef PFD_LOCK_DET_EN
  localparam int unsigned    LCW     = $clog2(LOCK_COUNT + 1);
  localparam logic [LCW-1:0] LCK_MAX = LCW'(LOCK_COUNT);
  localparam logic [WIDTH-1:0] THRESH = WIDTH'(LOCK_THRESH);

  logic [LCW-1:0] lock_cnt, lock_cnt_nxt;

  // Evaluated on the same cycle as the result so lock moves together with valid.
  always_comb begin
    lock_cnt_nxt = lock_cnt;
    if (valid_nxt) begin
      if (mag_nxt > THRESH)
        lock_cnt_nxt = '0;
      else if (lock_cnt != LCK_MAX)
        lock_cnt_nxt = lock_cnt + LCW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      lock_cnt <= '0;
      lock     <= 1'b0;
    end else begin
      lock_cnt <= lock_cnt_nxt;
      lock     <= (lock_cnt_nxt == LCK_MAX);
    end
  end
`endif

endmodule
